// File: rtl/serial_prefix_add_pkg.sv
// Shared types and helpers for the byte-serial prefix-adder sequencer.
package serial_prefix_add_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int SLICE_W = 8;

   function automatic int idx_width(input int nbytes);
      if (nbytes <= 1) return 1;
      return $clog2(nbytes);
   endfunction

endpackage

// File: rtl/serial_prefix_add_ctrl_if.sv
// Operand/result handshake bundle for serial_prefix_add_ctrl.
// SERIAL_PREFIX_ADD_SUB_EN adds the sub request bit.
interface serial_prefix_add_ctrl_if #(parameter int NBYTES = 4);
   import serial_prefix_add_pkg::*;

   localparam int WIDTH = SLICE_W * NBYTES;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             busy;
`ifdef SERIAL_PREFIX_ADD_SUB_EN
   logic             sub;

   modport master (output in_valid, a, b, sub, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf, busy);
   modport slave  (input  in_valid, a, b, sub, out_ready,
                   output in_ready, out_valid, sum, cout, ovf, busy);
`else
   modport master (output in_valid, a, b, out_ready,
                   input  in_ready, out_valid, sum, cout, ovf, busy);
   modport slave  (input  in_valid, a, b, out_ready,
                   output in_ready, out_valid, sum, cout, ovf, busy);
`endif

endinterface

// File: rtl/serial_prefix_add_ctrl_prefix_add8_ci.sv
// 8-bit Sklansky prefix adder slice with carry-in; purely combinational.
module prefix_add8_ci
   import serial_prefix_add_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout,
   output logic               c7
);

   // One Sklansky level: bit i combines with the top bit of the block below it.
   function automatic logic [SLICE_W-1:0] g_level(input logic [SLICE_W-1:0] g,
                                                  input logic [SLICE_W-1:0] p,
                                                  input int lvl);
      logic [SLICE_W-1:0] gn;
      int j;
      gn = g;
      for (int i = 0; i < SLICE_W; i++) begin
         if (((i >> lvl) & 1) == 1) begin
            j = ((i >> lvl) << lvl) - 1;
            gn[i[2:0]] = g[i[2:0]] | (p[i[2:0]] & g[j[2:0]]);
         end
      end
      return gn;
   endfunction

   function automatic logic [SLICE_W-1:0] p_level(input logic [SLICE_W-1:0] p,
                                                  input int lvl);
      logic [SLICE_W-1:0] pn;
      int j;
      pn = p;
      for (int i = 0; i < SLICE_W; i++) begin
         if (((i >> lvl) & 1) == 1) begin
            j = ((i >> lvl) << lvl) - 1;
            pn[i[2:0]] = p[i[2:0]] & p[j[2:0]];
         end
      end
      return pn;
   endfunction

   logic [SLICE_W-1:0] g0, p0, g1, p1, g2, p2, g3;
   logic [SLICE_W-1:0] carry;

   // Folding cin into bit 0's generate makes every G[i:0] include P[i:0]&cin.
   assign p0 = a ^ b;
   assign g0 = (a & b) | {{(SLICE_W-1){1'b0}}, p0[0] & cin};

   assign g1 = g_level(g0, p0, 0);
   assign p1 = p_level(p0, 0);
   assign g2 = g_level(g1, p1, 1);
   assign p2 = p_level(p1, 1);
   assign g3 = g_level(g2, p2, 2);

   assign carry = {g3[SLICE_W-2:0], cin};
   assign sum   = p0 ^ carry;
   assign cout  = g3[SLICE_W-1];
   assign c7    = g3[SLICE_W-2];

endmodule

// File: rtl/serial_prefix_add_ctrl.sv
// Byte-serial wide adder: one 8-bit prefix slice iterated LSB first with a registered carry.
// SERIAL_PREFIX_ADD_SUB_EN enables A-B via the sub handshake bit.
module serial_prefix_add_ctrl
   import serial_prefix_add_pkg::*;
#(
   parameter int NBYTES = 4
)(
   input logic                     clk,
   input logic                     rst_n,
   serial_prefix_add_ctrl_if.slave bus
);

   localparam int             WIDTH = SLICE_W * NBYTES;
   localparam int             IW    = idx_width(NBYTES);
   localparam logic [IW-1:0]  LAST  = IW'(NBYTES - 1);

   state_t             state;
   logic [IW-1:0]      idx;
   logic               carry;
   logic [WIDTH-1:0]   a_q, b_q, sum_q;
   logic               cout_q, ovf_q;
   logic               in_ready_q, out_valid_q, busy_q;

   logic [WIDTH-1:0]   b_in;
   logic               cin0;
   logic [SLICE_W-1:0] a_byte, b_byte, s_sum;
   logic               s_cout, s_c7;

`ifdef SERIAL_PREFIX_ADD_SUB_EN
   assign b_in = bus.sub ? ~bus.b : bus.b;
   assign cin0 = bus.sub;
`else
   assign b_in = bus.b;
   assign cin0 = 1'b0;
`endif

   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int k = 0; k < NBYTES; k++) begin
         if (idx == IW'(k)) begin
            a_byte = a_q[k*SLICE_W +: SLICE_W];
            b_byte = b_q[k*SLICE_W +: SLICE_W];
         end
      end
   end

   prefix_add8_ci u_slice (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry),
      .sum  (s_sum),
      .cout (s_cout),
      .c7   (s_c7)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idx         <= '0;
         carry       <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q        <= bus.a;
                  b_q        <= b_in;
                  carry      <= cin0;
                  idx        <= '0;
                  state      <= RUN;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            RUN: begin
               for (int k = 0; k < NBYTES; k++) begin
                  if (idx == IW'(k)) sum_q[k*SLICE_W +: SLICE_W] <= s_sum;
               end
               carry <= s_cout;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  cout_q      <= s_cout;
                  ovf_q       <= s_cout ^ s_c7;
                  state       <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.busy      = busy_q;

endmodule
